seq_cla_subtractor: RTL
=======================

Name: seq_cla_subtractor

Overview:
- Multi-cycle WIDTH-bit subtractor computing D = A - B - BIN, one 4-bit nibble per clock, LSB nibble first.
- Each nibble is formed with 4-bit borrow-lookahead logic, the subtract-side counterpart of the team's 4-bit carry-lookahead adder.
- Borrow chains between nibbles through a registered borrow bit.
- Used in the ALU datapath experiments where the operand is wider than one lookahead group and a start/done handshake is wanted.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request. Sampled only in IDLE.
- a  input  WIDTH  minuend. Captured on the accepted start edge.
- b  input  WIDTH  subtrahend. Captured on the accepted start edge.
- bin  input  1  borrow-in. Captured on the accepted start edge.
- busy  output  1  high while nibbles are being processed.
- done  output  1  one-cycle pulse when d/bout become valid.
- d  output  WIDTH  difference.
- bout  output  1  borrow-out of the MSB nibble (1 means a < b + bin, unsigned).

Behaviour:
- Reset: on a clk edge with rst_n=0, the block goes to IDLE and clears all of the following:
  - busy=0, done=0, d=0, bout=0
  - nibble counter=0, internal operand and borrow registers=0
- Reset overrides everything, including mid-operation. The in-flight op is discarded and no done is issued.
- N = WIDTH/4.
- States:
  - IDLE: busy=0. On an edge with start=1:
    - latch a, b, bin
    - cnt<=0
    - d<=0
    - busy<=1
    - go to RUN
  - RUN: every edge processes nibble k=cnt.
    - Operand bits: x=a[4k+3:4k], y=b[4k+3:4k], borrow-in Bi(0)=borrow register.
    - Per bit i:
      - g_i = ~x_i & y_i
      - p_i = ~(x_i ^ y_i)
      - Bi(i+1) = g_i | (p_i & Bi(i))
      - d_i = x_i ^ y_i ^ Bi(i)
    - Results: d[4k+3:4k] <= nibble result; borrow register <= Bi(4); cnt<=cnt+1.
    - On the edge processing k=N-1:
      - bout<=Bi(4)
      - busy<=0
      - done<=1
      - go to IDLE
- Latency: if start is accepted on edge E, done=1 and d/bout are valid after edge E+N, and busy is high from edge E to edge E+N. For WIDTH=16 that is 4 cycles.
- done is high for exactly one cycle, then cleared on the next edge.
- d and bout hold their values until the next accepted start, which clears d.
- start while busy=1 is ignored: no queuing, no effect on the in-flight op.
- start asserted in the same cycle as done (state is IDLE) is accepted. This gives back-to-back throughput of one op per N cycles.
- a, b and bin may change freely after the accepting edge. Only the latched copies are used.
- WIDTH=4: a single RUN edge, so done appears one cycle after start.

Optional Feature:
- Macro: SEQ_SUB_OVF_EN.
- Defined: adds output port ovf (1 bit).
  - Reset value 0, cleared on an accepted start.
  - Updated on the final RUN edge with the two's-complement overflow: ovf = (a[W-1]^b[W-1]) & (d[W-1]^a[W-1]), computed from the latched a/b and the final d.
  - Valid together with done.
- Undefined: no ovf port and no logic.

Decomposition:
- Package seq_sub_pkg contains:
  - constant NIBBLE=4
  - state enum {IDLE, RUN}
  - a function returning the counter width, $clog2(WIDTH/4) with a minimum of 1
- Sub-module nibble_borrow_la is purely combinational:
  - inputs: x[3:0], y[3:0], bi
  - outputs: d[3:0], bo
  - instantiated once and reused each cycle.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0234, bin=0, start pulse: busy high for 4 cycles, then done pulse with d=0x1000, bout=0.
- a=0x0000, b=0x0001, bin=0: d=0xFFFF, bout=1. With a=0x0005, b=0x0005, bin=1: d=0xFFFF, bout=1. With a=0xFFFF, b=0xFFFF, bin=0: d=0x0000, bout=0.
- Cross-nibble borrow ripple, a=0x1000, b=0x0001: d=0x0FFF, bout=0. Check nibble 0 produces a borrow that propagates through nibbles 1-2.
- start=1 held continuously with new operands each cycle: only ops whose start lands in IDLE are accepted. With a done pulse every 4 cycles, d matches only those accepted ops; mid-op operand changes have no effect.
- rst_n=0 for one edge during the second RUN cycle: busy=0, done=0, d=0, bout=0 next cycle, with no done pulse. A following start with a=0x0003, b=0x0001 gives d=0x0002.
- With SEQ_SUB_OVF_EN: a=0x8000, b=0x0001 gives d=0x7FFF, ovf=1, bout=0; a=0x7FFF, b=0xFFFF gives d=0x8000, ovf=1, bout=1; a=0x0005, b=0x0003 gives ovf=0.

Source files
------------

// File: rtl/seq_sub_pkg.sv
// rtl/seq_sub_pkg.sv - shared constants, state type and sizing helper for the sequential subtractor
package seq_sub_pkg;

   localparam int NIBBLE = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Counter width for WIDTH/NIBBLE nibbles, never narrower than one bit
   function automatic int cnt_width(input int width);
      int n;
      n = width / NIBBLE;
      if (n <= 1)
         return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/nibble_borrow_la.sv
// rtl/nibble_borrow_la.sv - 4-bit borrow-lookahead subtract slice
module nibble_borrow_la
   import seq_sub_pkg::*;
(
   input  logic [NIBBLE-1:0] x,
   input  logic [NIBBLE-1:0] y,
   input  logic              bi,
   output logic [NIBBLE-1:0] d,
   output logic              bo
);

   logic [NIBBLE-1:0] w_g;
   logic [NIBBLE-1:0] w_p;
   logic [NIBBLE:0]   w_b;

   // Generate when minuend bit is 0 and subtrahend bit is 1; propagate when the bits are equal
   assign w_g = ~x & y;
   assign w_p = ~(x ^ y);

   // Every internal borrow is flattened so no bit waits on its neighbour
   assign w_b[0] = bi;
   assign w_b[1] = w_g[0] | (w_p[0] & bi);
   assign w_b[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & bi);
   assign w_b[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & bi);
   assign w_b[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & bi);

   assign d  = x ^ y ^ w_b[NIBBLE-1:0];
   assign bo = w_b[NIBBLE];

endmodule

// File: rtl/seq_cla_subtractor.sv
// rtl/seq_cla_subtractor.sv - nibble-serial A-B-BIN subtractor with start/done handshake; SEQ_SUB_OVF_EN adds ovf
module seq_cla_subtractor
   import seq_sub_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout
`ifdef SEQ_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int N  = WIDTH / NIBBLE;
   localparam int CW = cnt_width(WIDTH);

   generate
      if ((WIDTH % NIBBLE) != 0 || WIDTH < NIBBLE) begin : g_bad_width
         $error("seq_cla_subtractor: WIDTH must be a multiple of 4 and at least 4");
      end
   endgenerate

   state_t            r_state;
   state_t            w_state_next;
   logic              w_accept;
   logic              w_last;

   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic              r_borrow;
   logic [CW-1:0]     r_cnt;
   logic [WIDTH-1:0]  r_d;
   logic              r_bout;
   logic              r_busy;
   logic              r_done;

   logic [WIDTH-1:0]  w_a_sh;
   logic [WIDTH-1:0]  w_b_sh;
   logic [NIBBLE-1:0] w_nd;
   logic              w_nbo;

   // The current nibble is always at the bottom after shifting by 4*cnt
   assign w_a_sh = r_a >> {r_cnt, 2'b00};
   assign w_b_sh = r_b >> {r_cnt, 2'b00};
   assign w_last = (r_state == RUN) && (r_cnt == CW'(N - 1));

   nibble_borrow_la u_nibble (
      .x  (w_a_sh[NIBBLE-1:0]),
      .y  (w_b_sh[NIBBLE-1:0]),
      .bi (r_borrow),
      .d  (w_nd),
      .bo (w_nbo)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   // Next state: start is only honoured in IDLE, RUN leaves after the top nibble
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_state_next = RUN;
            end
         end
         RUN: begin
            if (w_last)
               w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Datapath: latch operands on accept, then fold one nibble result into d per RUN edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
         r_d      <= '0;
         r_bout   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
            r_d      <= '0;
            r_busy   <= 1'b1;
         end else if (r_state == RUN) begin
            // d was cleared on accept, so OR-ing the shifted nibble is a plain write
            r_d      <= r_d | (WIDTH'(w_nd) << {r_cnt, 2'b00});
            r_borrow <= w_nbo;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
               r_bout <= w_nbo;
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

`ifdef SEQ_SUB_OVF_EN
   logic r_ovf;

   // Signed overflow: operand signs differ and the result sign differs from the minuend
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_ovf <= 1'b0;
      else if (w_accept)
         r_ovf <= 1'b0;
      else if (w_last)
         r_ovf <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_nd[NIBBLE-1] ^ r_a[WIDTH-1]);
   end

   assign ovf = r_ovf;
`endif

   assign busy = r_busy;
   assign done = r_done;
   assign d    = r_d;
   assign bout = r_bout;

endmodule
